recirc_shift_mem: RTL
=====================

Name: recirc_shift_mem

Overview:
- Parametrised successor to the 6x40 dynamic recirculating shift-register memory used as the video terminal's character store.
- Generalises the store in width and depth, and adds:
  - a shift enable, so the store advances only on character-slot clocks;
  - a head-position counter with a wrap strobe, for cursor and row alignment;
  - a self-timed bulk-clear sequence, for screen clear.
- Sits between the terminal input logic and the character generator.

Parameters:
- WIDTH, 6, bits per stored word (one bit-lane per data bit).
- DEPTH, 40, words per recirculating loop; must be at least 2.
- FILL_VALUE, 0, WIDTH-bit word written into every location by a clear sequence.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- shift_en  in  1  advances the loop by one word on a rising clk edge while high.
- rc  in  1  1 = recirculate dout into stage 0; 0 = load din into stage 0.
- din  in  WIDTH  word loaded when rc=0.
- clear_req  in  1  single-cycle request to start a clear sequence.
- dout  out  WIDTH  word in the last stage (stage DEPTH-1), combinational from storage.
- pos  out  max(1,$clog2(DEPTH))  index of the word currently at dout, 0..DEPTH-1.
- wrap  out  1  one-cycle pulse on the shift that moves pos from DEPTH-1 to 0.
- busy  out  1  high while a clear sequence is in progress.

Behaviour:
- Reset, applied on a rising clk edge while reset=1:
  - all storage cleared to 0, so dout=0;
  - pos=0, wrap=0, busy=0, FSM in IDLE;
  - reset overrides every other input, including a clear in progress, which is abandoned.
- Shift, when shift_en=1 on an edge:
  - stage[i] takes stage[i-1] for i = 1..DEPTH-1;
  - stage[0] takes the selected source;
  - every bit-lane shifts in lockstep.
- Source selection priority: FSM in CLEAR selects FILL_VALUE; otherwise rc=1 selects dout; otherwise din.
- When shift_en=0: storage, pos and FSM state hold; wrap=0.
- Latency: a word entered at shift N appears on dout after shift N+DEPTH-1 completes, and re-enters stage 0 at shift N+DEPTH when rc=1.
- pos:
  - increments by 1 on each shift;
  - DEPTH-1 wraps to 0 with no out-of-range value, including when DEPTH is not a power of two.
- wrap: registered; equals 1 for exactly the cycle after the shift edge on which pos went DEPTH-1 to 0.
- FSM, IDLE to CLEAR:
  - triggered by clear_req=1 on an edge in IDLE;
  - busy=1 from the next cycle;
  - shift counter loaded to 0;
  - that edge performs no fill write, even if shift_en=1.
- FSM, CLEAR to IDLE:
  - each shift in CLEAR writes FILL_VALUE and increments the counter;
  - after exactly DEPTH shifts the FSM returns to IDLE and busy=0 on the following cycle;
  - every location then holds FILL_VALUE;
  - pos continues to advance normally throughout.
- clear_req while busy=1: ignored; no restart and no queuing.
- shift_en=0 during CLEAR: the sequence stalls and completes only after DEPTH enabled shifts.
- rc and din are ignored while busy=1.

Decomposition:
- No shared package is needed; the FSM state encoding (IDLE, CLEAR) stays local.
- One natural sub-module, mod_counter (parameter MOD, ports clk, reset, en, count, wrap), instanced twice:
  - once for pos/wrap, with MOD=DEPTH;
  - once for the clear shift counter.

Test Plan:
- Load, defaults: rc=0, shift_en=1, din=0x01..0x28 over 40 shifts, then rc=1 -> dout shows 0x01 immediately after shift 40, then 0x02..0x28 and back to 0x01; pattern stable across 3 full loops.
- Gated shift: as above, with shift_en toggled 1/0 every cycle -> identical dout sequence at half rate; pos advances only on enabled edges.
- Counter: 100 consecutive shifts -> pos sequence 0..39,0..39,0..19; wrap high exactly twice, in the cycles after shifts 40 and 80.
- Clear: store loaded with 0x15, clear_req pulsed, shift_en=1 -> busy high for exactly 40 enabled shifts; then every dout word = FILL_VALUE (test both FILL_VALUE=0 and 0x20); a second clear_req mid-clear has no effect.
- Reset mid-clear: reset at shift 17 of a clear -> next cycle busy=0, pos=0, dout=0; a subsequent 40-shift recirculate reads all zeros.
- Alternate parameters WIDTH=8, DEPTH=24: repeat the load and counter tests -> pos wraps 23 to 0 and the loop period is 24 shifts.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD up-counter with a registered wrap strobe
module mod_counter #(
    parameter int MOD = 40
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    output logic [$clog2(MOD)-1:0] count,
    output logic                   wrap
);
    localparam int W = $clog2(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);
    // Advance on enable, folding MOD-1 straight back to 0 so non-power-of-two moduli never overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= en && count == LAST;
            if (en) count <= count == LAST ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/recirc_shift_mem.sv
// recirc_shift_mem: gated recirculating shift-register store with head position and self-timed clear
module recirc_shift_mem #(
    parameter int               WIDTH      = 6,
    parameter int               DEPTH      = 40,
    parameter logic [WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     rc,
    input  logic [WIDTH-1:0]         din,
    input  logic                     clear_req,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH)-1:0] pos,
    output logic                     wrap,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0] clr_cnt;
    logic clr_wrap_unused;
    logic clearing;
    logic clr_en;
    logic [WIDTH-1:0] src;
    assign clearing = state == CLEAR;
    assign busy     = clearing;
    assign clr_en   = shift_en && clearing;
    assign dout     = mem[DEPTH-1];
    assign src      = clearing ? FILL_VALUE : rc ? dout : din;
    // Whole loop moves one word per enabled edge; stage 0 takes the selected source
    always_ff @(posedge clk) begin
        if (reset) mem <= '0;
        else if (shift_en) mem <= {mem[DEPTH-2:0], src};
    end
    // Clear sequencer: start from IDLE only, finish on the DEPTH-th enabled fill shift
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else if (!clearing && clear_req) state <= CLEAR;
        else if (clr_en && clr_cnt == LAST) state <= IDLE;
    end
    mod_counter #(.MOD(DEPTH)) u_pos (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .count (pos),
        .wrap  (wrap)
    );
    // Held at zero outside CLEAR so each sequence starts counting from 0
    mod_counter #(.MOD(DEPTH)) u_clr (
        .clk   (clk),
        .reset (reset || !clearing),
        .en    (clr_en),
        .count (clr_cnt),
        .wrap  (clr_wrap_unused)
    );
endmodule
